// File: rtl/riscv_pkg.sv
// Constants shared by the RV32 pipeline stages.
package riscv_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;
endpackage

// File: rtl/riscv_32_fetch_stage.sv
// Fetch stage: owns the PC, drives the synchronous instruction ROM address and
// holds the F/EX register feeding the decoder. Redirects squash with a NOP bubble.
module riscv_32_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_ex,
  output logic [31:0] pc_ex,
  output logic [31:0] pc_plus4_ex,
  output logic        valid_ex
);

  logic [31:0] pc_f_q, pc_f_d;
  logic        f_valid_q;
  logic [31:0] instr_ex_q, instr_ex_d;
  logic [31:0] pc_ex_q, pc_ex_d;
  logic        valid_ex_q, valid_ex_d;
  logic [31:0] redirect_tgt;

  // Low address bits of a target are dropped; misalignment is not reported.
  assign redirect_tgt = redirect_pc & ~32'h0000_0003;

  always_comb begin
    pc_f_d = pc_f_q + PC_STEP;
    if (redirect) begin
      pc_f_d = redirect_tgt;
    end else if (!f_valid_q || stall) begin
      pc_f_d = pc_f_q;
    end
  end

  always_comb begin
    instr_ex_d = instr_ex_q;
    pc_ex_d    = pc_ex_q;
    valid_ex_d = valid_ex_q;
    if (redirect) begin
      instr_ex_d = NOP_INSTR;
      valid_ex_d = 1'b0;
    end else if (!stall) begin
      instr_ex_d = f_valid_q ? imem_rdata : NOP_INSTR;
      valid_ex_d = f_valid_q;
      pc_ex_d    = pc_f_q;
    end
  end

  // pc_f always tracks the address presented last cycle, so imem_rdata matches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_q     <= RESET_PC;
      f_valid_q  <= 1'b0;
      instr_ex_q <= NOP_INSTR;
      pc_ex_q    <= RESET_PC;
      valid_ex_q <= 1'b0;
    end else begin
      pc_f_q     <= pc_f_d;
      f_valid_q  <= 1'b1;
      instr_ex_q <= instr_ex_d;
      pc_ex_q    <= pc_ex_d;
      valid_ex_q <= valid_ex_d;
    end
  end

  assign imem_addr   = rst ? RESET_PC : pc_f_d;
  assign instr_ex    = instr_ex_q;
  assign pc_ex       = pc_ex_q;
  assign valid_ex    = valid_ex_q;
  assign pc_plus4_ex = pc_ex_q + PC_STEP;

endmodule

// File: tb/tb_riscv_32_fetch_stage.sv
// Bench for riscv_32_fetch_stage: directed literal checks plus randomized
// stall/redirect traffic compared against an instruction-stream model.
module tb_riscv_32_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] addr_a, rdata_a, instr_a, pc_a, pc4_a;
  logic        valid_a;
  logic        stall_b, redirect_b;
  logic [31:0] redirect_pc_b;
  logic [31:0] addr_b, rdata_b, instr_b, pc_b, pc4_b;
  logic        valid_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  always @(posedge clk) rdata_a <= rom(addr_a);
  always @(posedge clk) rdata_b <= rom(addr_b);

  riscv_32_fetch_stage #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(addr_a), .imem_rdata(rdata_a),
    .instr_ex(instr_a), .pc_ex(pc_a), .pc_plus4_ex(pc4_a), .valid_ex(valid_a)
  );

  riscv_32_fetch_stage #(.RESET_PC(RPC_B)) dut_b (
    .clk(clk), .rst(rst), .stall(stall_b), .redirect(redirect_b),
    .redirect_pc(redirect_pc_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
    .instr_ex(instr_b), .pc_ex(pc_b), .pc_plus4_ex(pc4_b), .valid_ex(valid_b)
  );

  // Model of dut_a: the PC of the next instruction to be delivered, and
  // whether its ROM read is already in flight.
  logic [31:0] m_next, m_pc_ex, m_instr;
  logic        m_valid, m_primed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_next   = 32'h0;
    m_pc_ex  = 32'h0;
    m_instr  = NOP;
    m_valid  = 1'b0;
    m_primed = 1'b0;
  endtask

  function automatic logic [31:0] model_addr();
    if (rst) return 32'h0;
    if (redirect) return redirect_pc & ~32'h3;
    if (!m_primed || stall) return m_next;
    return m_next + 32'd4;
  endfunction

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (redirect) begin
      m_instr  = NOP;
      m_valid  = 1'b0;
      m_next   = redirect_pc & ~32'h3;
      m_primed = 1'b1;
    end else if (stall) begin
      m_primed = 1'b1;
    end else if (m_primed) begin
      m_pc_ex = m_next;
      m_instr = rom(m_next);
      m_valid = 1'b1;
      m_next  = m_next + 32'd4;
    end else begin
      m_instr  = NOP;
      m_valid  = 1'b0;
      m_pc_ex  = m_next;
      m_primed = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    chk("pc_ex", pc_a, m_pc_ex);
    chk("instr_ex", instr_a, m_instr);
    chk("valid_ex", {31'b0, valid_a}, {31'b0, m_valid});
    chk("pc_plus4_ex", pc4_a, m_pc_ex + 32'd4);
  endtask

  // One clock: check the address for the current inputs, take the edge,
  // advance the model, then check registered outputs 1 time unit later.
  task automatic step();
    #1;
    chk("imem_addr", addr_a, model_addr());
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = 32'h0;
    model_reset();
    #12;
    chk("rst_valid", {31'b0, valid_a}, 32'h0);
    chk("rst_addr", addr_a, 32'h0);
    chk("rst_instr", instr_a, NOP);
    chk("rst_addr_b", addr_b, RPC_B);
    chk("rst_pc_b", pc_b, RPC_B);
    rst = 1'b0;

    step();
    chk("edge0_valid", {31'b0, valid_a}, 32'h0);
    step();
    chk("edge1_pc", pc_a, 32'h0);
    chk("edge1_instr", instr_a, 32'h1000_0000);
    chk("edge1_valid", {31'b0, valid_a}, 32'h1);
    chk("wrap_pc_b0", pc_b, 32'hFFFF_FFF8);
    step();
    chk("seq_pc4", pc_a, 32'h4);
    chk("wrap_pc_b1", pc_b, 32'hFFFF_FFFC);
    chk("wrap_plus4_b", pc4_b, 32'h0);
    step();
    chk("seq_pc8", pc_a, 32'h8);
    chk("wrap_pc_b2", pc_b, 32'h0);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc_a, 32'h8);
      chk("stall_instr", instr_a, 32'h1000_0002);
    end
    stall = 1'b0;
    step();
    chk("post_stall_pc", pc_a, 32'hC);
    chk("post_stall_instr", instr_a, 32'h1000_0003);

    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    chk("bubble_valid", {31'b0, valid_a}, 32'h0);
    chk("bubble_instr", instr_a, NOP);
    redirect = 1'b0;
    step();
    chk("tgt_pc", pc_a, 32'h40);
    chk("tgt_instr", instr_a, 32'h1000_0010);

    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h22;
    step();
    chk("rs_bubble", {31'b0, valid_a}, 32'h0);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk("rs_tgt_pc", pc_a, 32'h20);
    chk("rs_tgt_instr", instr_a, 32'h1000_0008);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        stall = 1'b0; redirect = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, valid_a}, 32'h0);
        chk("arst_addr", addr_a, 32'h0);
        chk("arst_pc", pc_a, 32'h0);
        model_reset();
        step();
        #2;
        rst = 1'b0;
        step();
        step();
        chk("restart_pc", pc_a, 32'h0);
        chk("restart_instr", instr_a, 32'h1000_0000);
        chk("restart_valid", {31'b0, valid_a}, 32'h1);
      end
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
